// File: rtl/sampletest_arbiter_if.sv
// Lane-side and datapath-side signals of the sampletest arbiter.
// The arbiter connects through the slave modport; whatever drives the lane
// requests and models the shared sampletest unit uses the master modport.
interface sampletest_arbiter_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);

    // Per-lane requests from the two sample iterators
    logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_req_R16S;
    logic        [1:0][COLORS-1:0][SIGFIG-1:0]          color_req_R16U;
    logic signed [1:0][1:0][SIGFIG-1:0]                 sample_req_R16S;
    logic        [1:0]                                  validSamp_req_R16H;
    logic        [1:0]                                  halt_req_R16H;
    logic        [1:0]                                  busy_R16H;

    // Granted lane muxed into the shared sampletest unit
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      tri_R16S;
    logic        [COLORS-1:0][SIGFIG-1:0]               color_R16U;
    logic signed [1:0][SIGFIG-1:0]                      sample_R16S;
    logic                                               validSamp_R16H;

    // Hit result coming back and its steering
    logic                                               hit_valid_R18H;
    logic        [1:0]                                  hit_valid_lane_R18H;
    logic                                               tag_valid_R18H;
    logic                                               tag_R18U;

    modport slave (
        input  tri_req_R16S,
        input  color_req_R16U,
        input  sample_req_R16S,
        input  validSamp_req_R16H,
        input  hit_valid_R18H,
        output halt_req_R16H,
        output busy_R16H,
        output tri_R16S,
        output color_R16U,
        output sample_R16S,
        output validSamp_R16H,
        output hit_valid_lane_R18H,
        output tag_valid_R18H,
        output tag_R18U
    );

    modport master (
        output tri_req_R16S,
        output color_req_R16U,
        output sample_req_R16S,
        output validSamp_req_R16H,
        output hit_valid_R18H,
        input  halt_req_R16H,
        input  busy_R16H,
        input  tri_R16S,
        input  color_R16U,
        input  sample_R16S,
        input  validSamp_R16H,
        input  hit_valid_lane_R18H,
        input  tag_valid_R18H,
        input  tag_R18U
    );

endinterface

// File: rtl/sampletest_arbiter.sv
// Two-lane round-robin arbiter in front of one shared sampletest datapath.
// A {valid, lane} tag rides a PIPE_DEPTH-deep shadow pipe alongside the
// shared unit so each R18 hit is steered back to the lane that issued it.
// Per-lane in-flight counters tell each iterator when its samples drained.
module sampletest_arbiter #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int PIPE_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    sampletest_arbiter_if.slave bus
);

    localparam int cnt_width = $clog2(PIPE_DEPTH + 1);

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic        [COLORS-1:0][SIGFIG-1:0]          color_t;
    typedef logic signed [1:0][SIGFIG-1:0]                 sample_t;

    // Reject parameter sets the shared datapath cannot use
    if (PIPE_DEPTH < 1) begin : g_bad_depth
        $error("sampletest_arbiter: PIPE_DEPTH must be at least 1");
    end
    if (RADIX < 0 || RADIX >= SIGFIG) begin : g_bad_radix
        $error("sampletest_arbiter: RADIX must lie in 0..SIGFIG-1");
    end

    // Arbitration
    logic [1:0] req;
    logic [1:0] grant;
    logic       any_grant;
    logic       grant_lane;
    logic       ptr_q;
    logic       ptr_d;

    // Shadow tag pipe; stage 0 is loaded at R16, the last stage is R18
    logic [PIPE_DEPTH-1:0] tag_valid_q;
    logic [PIPE_DEPTH-1:0] tag_valid_d;
    logic [PIPE_DEPTH-1:0] tag_lane_q;
    logic [PIPE_DEPTH-1:0] tag_lane_d;
    logic                  exit_valid;
    logic                  exit_lane;

    // In-flight accounting
    logic [1:0][cnt_width-1:0] cnt_q;
    logic [1:0][cnt_width-1:0] cnt_d;
    logic [1:0]                cnt_inc;
    logic [1:0]                cnt_dec;

    // Selected lane payload
    tri_t    tri_sel;
    color_t  color_sel;
    sample_t sample_sel;

    assign req        = bus.validSamp_req_R16H;
    assign any_grant  = |grant;
    assign grant_lane = grant[1];
    assign exit_valid = tag_valid_q[PIPE_DEPTH-1];
    assign exit_lane  = tag_lane_q[PIPE_DEPTH-1];

    // Round-robin grant: a lone requester wins outright, a tie goes to ptr_q
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer moves to the loser of this cycle only when someone was granted
    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            ptr_d = ~grant_lane;
        end
    end

    // Lane-facing handshake: a requesting lane that lost must hold its inputs
    always_comb begin
        bus.halt_req_R16H = req & ~grant;
        for (int i = 0; i < 2; i++) begin
            bus.busy_R16H[i] = req[i] | (cnt_q[i] != '0);
        end
    end

    // Payload mux; with no grant lane 0 is passed through to keep the mux simple
    always_comb begin
        tri_sel            = bus.tri_req_R16S[grant_lane];
        color_sel          = bus.color_req_R16U[grant_lane];
        sample_sel         = bus.sample_req_R16S[grant_lane];
        bus.tri_R16S       = tri_sel;
        bus.color_R16U     = color_sel;
        bus.sample_R16S    = sample_sel;
        bus.validSamp_R16H = any_grant;
    end

    // Tag pipe next state: load this cycle's grant, shift the rest, never stall
    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_lane_d     = tag_lane_q;
        tag_valid_d[0] = any_grant;
        tag_lane_d[0]  = grant_lane;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_lane_d[s]  = tag_lane_q[s-1];
        end
    end

    // Hit steering; a hit with no live tag has no owner and is dropped
    always_comb begin
        bus.hit_valid_lane_R18H    = 2'b00;
        bus.hit_valid_lane_R18H[0] = bus.hit_valid_R18H & exit_valid & ~exit_lane;
        bus.hit_valid_lane_R18H[1] = bus.hit_valid_R18H & exit_valid & exit_lane;
        bus.tag_valid_R18H         = exit_valid;
        bus.tag_R18U               = exit_lane;
    end

    assign cnt_inc = grant;
    assign cnt_dec = {exit_valid & exit_lane, exit_valid & ~exit_lane};

    // In-flight counters: entry and exit in the same cycle cancel out
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (cnt_inc[i] && !cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] + cnt_width'(1);
            end else if (!cnt_inc[i] && cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] - cnt_width'(1);
            end
        end
    end

    // State registers; reset discards every in-flight tag immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            tag_valid_q <= '0;
            tag_lane_q  <= '0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_valid_q <= tag_valid_d;
            tag_lane_q  <= tag_lane_d;
            cnt_q       <= cnt_d;
        end
    end

    // Invariants: one grant at most, counters stay within the pipe depth
    assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    assert property (@(posedge clk) disable iff (rst) (grant & ~req) == 2'b00);

    for (genvar i = 0; i < 2; i++) begin : g_cnt_chk
        assert property (@(posedge clk) disable iff (rst)
            cnt_q[i] <= cnt_width'(PIPE_DEPTH));
        assert property (@(posedge clk) disable iff (rst)
            !(cnt_q[i] == '0 && cnt_dec[i] && !cnt_inc[i]));
    end

endmodule

// File: tb/tb_sampletest_arbiter.sv
// Scoreboard bench for sampletest_arbiter: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares per-cycle outputs and
// steered hits. A small stub stands in for the shared sampletest unit.
module tb_sampletest_arbiter;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int PD     = 2;
    localparam int TW     = VERTS * AXIS * SIGFIG;
    localparam int CW     = COLORS * SIGFIG;
    localparam int SW     = 2 * SIGFIG;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic orphan = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sampletest_arbiter_if #(
        .SIGFIG(SIGFIG),
        .VERTS (VERTS),
        .AXIS  (AXIS),
        .COLORS(COLORS)
    ) bus ();

    sampletest_arbiter #(
        .SIGFIG    (SIGFIG),
        .RADIX     (RADIX),
        .VERTS     (VERTS),
        .AXIS      (AXIS),
        .COLORS    (COLORS),
        .PIPE_DEPTH(PD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stand-in for sampletest: a sample hits when its low sample bit is set
    logic [PD-1:0] hit_pipe;
    always @(posedge clk or posedge rst) begin
        if (rst) hit_pipe <= '0;
        else     hit_pipe <= {hit_pipe[PD-2:0], bus.validSamp_R16H & bus.sample_R16S[0][0]};
    end
    assign bus.hit_valid_R18H = hit_pipe[PD-1] | orphan;

    typedef struct {
        logic [1:0]    grant;
        logic [1:0]    halt;
        logic [1:0]    busy;
        logic          tagv;
        logic          tag;
        logic [TW-1:0] tri_v;
        logic [CW-1:0] col_v;
        logic [SW-1:0] smp_v;
    } r16_t;

    typedef struct {
        int         cyc;
        logic [1:0] mask;
    } hit_t;

    r16_t r16_q[$];
    hit_t hit_q[$];
    r16_t mon_e;
    hit_t mon_h;

    logic [TW-1:0] tri_c[2];
    logic [CW-1:0] col_c[2];

    function automatic logic [SW-1:0] smp(input int l, input logic h);
        return {SIGFIG'(32'h100 + l), SIGFIG'((l + 7) * 2) | SIGFIG'(h)};
    endfunction

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pop one per-cycle expectation, and one hit whenever a hit shows
    always @(negedge clk) begin
        if (r16_q.size() > 0) begin
            mon_e = r16_q.pop_front();
            check("grant_valid", TW'(bus.validSamp_R16H), TW'(|mon_e.grant));
            check("halt", TW'(bus.halt_req_R16H), TW'(mon_e.halt));
            check("busy", TW'(bus.busy_R16H), TW'(mon_e.busy));
            check("tag_valid", TW'(bus.tag_valid_R18H), TW'(mon_e.tagv));
            check("tag_lane", TW'(bus.tag_R18U), TW'(mon_e.tag));
            check("tri_mux", $unsigned(bus.tri_R16S), mon_e.tri_v);
            check("color_mux", TW'(bus.color_R16U), TW'(mon_e.col_v));
            check("sample_mux", TW'($unsigned(bus.sample_R16S)), TW'(mon_e.smp_v));
        end
        if (bus.hit_valid_lane_R18H != 2'b00) begin
            if (hit_q.size() == 0) begin
                check("unexpected_hit", TW'(bus.hit_valid_lane_R18H), '0);
            end else begin
                mon_h = hit_q.pop_front();
                check("hit_mask", TW'(bus.hit_valid_lane_R18H), TW'(mon_h.mask));
                check("hit_cycle", TW'(cyc), TW'(mon_h.cyc));
            end
        end else if (hit_q.size() > 0 && hit_q[0].cyc <= cyc) begin
            mon_h = hit_q.pop_front();
            check("missing_hit", TW'(bus.hit_valid_lane_R18H), TW'(mon_h.mask));
        end
    end

    // One cycle of stimulus plus its expected R16/R18 view and any later hit
    task automatic step(input logic r, input logic [1:0] vld, input logic [1:0] hb,
                        input logic orph, input logic [1:0] eg, input logic [1:0] eh,
                        input logic [1:0] eb, input logic etv, input logic et,
                        input logic [1:0] ehit);
        r16_t e;
        hit_t h;
        int   l;
        @(posedge clk);
        #1;
        rst                    = r;
        orphan                 = orph;
        bus.validSamp_req_R16H = vld;
        bus.sample_req_R16S    = {smp(1, hb[1]), smp(0, hb[0])};
        l       = eg[1] ? 1 : 0;
        e.grant = eg;
        e.halt  = eh;
        e.busy  = eb;
        e.tagv  = etv;
        e.tag   = et;
        e.tri_v = tri_c[l];
        e.col_v = col_c[l];
        e.smp_v = smp(l, hb[l]);
        r16_q.push_back(e);
        if (ehit != 2'b00) begin
            h.cyc  = cyc + PD;
            h.mask = ehit;
            hit_q.push_back(h);
        end
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < VERTS * AXIS; k++) tri_c[l][k*SIGFIG +: SIGFIG] = SIGFIG'(l * 1000 + k + 1);
            for (int k = 0; k < COLORS; k++) col_c[l][k*SIGFIG +: SIGFIG] = SIGFIG'(32'h500 + l * 16 + k);
        end
        bus.tri_req_R16S       = {tri_c[1], tri_c[0]};
        bus.color_req_R16U     = {col_c[1], col_c[0]};
        bus.sample_req_R16S    = {smp(1, 1'b0), smp(0, 1'b1)};
        bus.validSamp_req_R16H = 2'b11;
        #1 rst = 1'b1;

        //   rst vld   hit   orph grant halt  busy  tv  tag hit@+PD
        // Reset held with both lanes requesting
        step(1, 2'b11, 2'b01, 0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b00);
        step(1, 2'b11, 2'b01, 0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b00);
        // Alternation: lane 0 hits, lane 1 misses
        step(0, 2'b11, 2'b01, 0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b01);
        step(0, 2'b11, 2'b01, 0, 2'b10, 2'b01, 2'b11, 0, 0, 2'b00);
        step(0, 2'b11, 2'b01, 0, 2'b01, 2'b10, 2'b11, 1, 0, 2'b01);
        step(0, 2'b11, 2'b01, 0, 2'b10, 2'b01, 2'b11, 1, 1, 2'b00);
        step(0, 2'b11, 2'b01, 0, 2'b01, 2'b10, 2'b11, 1, 0, 2'b01);
        step(0, 2'b11, 2'b01, 0, 2'b10, 2'b01, 2'b11, 1, 1, 2'b00);
        // Lane 1 alone, every sample hits
        step(0, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b11, 1, 0, 2'b10);
        step(0, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b10, 1, 1, 2'b10);
        step(0, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b10, 1, 1, 2'b10);
        step(0, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b10, 1, 1, 2'b10);
        // Tie after lane-1 run: pointer must be back at lane 0
        step(0, 2'b11, 2'b00, 0, 2'b01, 2'b10, 2'b11, 1, 1, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11, 1, 1, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        // Single lane-0 grant then idle: busy drops once the tag has exited
        step(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        // Back-to-back lane-0 grants: counter saturates at PIPE_DEPTH
        step(0, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b01);
        step(0, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b01);
        step(0, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b01, 1, 0, 2'b01);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        // Grants to both lanes (pointer left at lane 1), then mid-cycle reset
        step(0, 2'b11, 2'b11, 0, 2'b10, 2'b01, 2'b11, 0, 0, 2'b00);
        step(0, 2'b11, 2'b11, 0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b00);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        // Orphan hits with no live tag are dropped
        step(0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        step(0, 2'b10, 2'b10, 1, 2'b10, 2'b00, 2'b10, 0, 0, 2'b10);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b10, 0, 0, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b10, 1, 1, 2'b00);
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);

        @(negedge clk);
        #1;
        check("queues_drained", TW'(r16_q.size() + hit_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
